// File: rtl/main_control_fsm.sv
// Multicycle MIPS main control unit: sequences fetch/decode/execute/memory/writeback
// and drives every datapath control line, including ALUop for the ALU control decoder.
module main_control_fsm #(
    parameter int unsigned OPW = 6
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [OPW-1:0] opcode,
    input  logic           jr,
    input  logic           mem_ready,
    output logic           PCWrite,
    output logic           PCWriteCond,
    output logic           IorD,
    output logic           MemRead,
    output logic           MemWrite,
    output logic           MemtoReg,
    output logic           IRWrite,
    output logic           ALUSrcA,
    output logic           RegWrite,
    output logic           RegDst,
    output logic [1:0]     PCSource,
    output logic [1:0]     ALUSrcB,
    output logic [1:0]     ALUop,
    output logic           instr_done,
    output logic           illegal_op,
    output logic [3:0]     state
);

    localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_ANDI  = OPW'(6'b001100);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);

    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_OUT  = 2'b01;
    localparam logic [1:0] PCSRC_JMP  = 2'b10;
    localparam logic [1:0] PCSRC_REGA = 2'b11;

    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM4 = 2'b11;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_FUNC = 2'b10;
    localparam logic [1:0] ALU_ANDI = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RCOMP  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ANDIEX = 4'd10,
        S_ANDIWB = 4'd11,
        S_JREG   = 4'd12
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   op_known;
    logic   illegal_q;

    assign op_known = (opcode == OP_LW)  || (opcode == OP_SW)  ||
                      (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
                      (opcode == OP_J)   || (opcode == OP_ANDI);

    // State register and sticky illegal-opcode flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE && !op_known) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // Next-state sequencing
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEMADR;
                else if (opcode == OP_RTYPE)            state_d = S_EXEC;
                else if (opcode == OP_BEQ)              state_d = S_BRANCH;
                else if (opcode == OP_J)                state_d = S_JUMP;
                else if (opcode == OP_ANDI)             state_d = S_ANDIEX;
                else                                    state_d = S_FETCH;
            end
            // IR is stable here, so the opcode can be looked at again
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: state_d = S_FETCH;
            S_MEMWR: begin
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC:   state_d = jr ? S_JREG : S_RCOMP;
            S_RCOMP:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_ANDIEX: state_d = S_ANDIWB;
            S_ANDIWB: state_d = S_FETCH;
            S_JREG:   state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Control line decode from the current state
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        PCSource    = PCSRC_ALU;
        ALUSrcB     = SRCB_REGB;
        ALUop       = ALU_ADD;
        instr_done  = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcB    = SRCB_IMM4;
                instr_done = !op_known;
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
            end
            S_MEMWR: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUop   = ALU_FUNC;
            end
            S_RCOMP: begin
                ALUop      = ALU_FUNC;
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUop       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_OUT;
                instr_done  = 1'b1;
            end
            S_JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_JMP;
                instr_done = 1'b1;
            end
            S_ANDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUop   = ALU_ANDI;
            end
            S_ANDIWB: begin
                ALUop      = ALU_ANDI;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_JREG: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_REGA;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        // An aborted instruction must not commit anything while reset is held
        if (reset) begin
            PCWrite    = 1'b0;
            IRWrite    = 1'b0;
            instr_done = 1'b0;
        end
    end

    assign illegal_op = illegal_q;
    assign state      = state_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// Randomized self-checking bench for main_control_fsm: an instruction-level model
// expands each instruction into its expected state/output trace.
module tb_main_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       jr;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
    logic       ALUSrcA, RegWrite, RegDst, instr_done, illegal_op;
    logic [1:0] PCSource, ALUSrcB, ALUop;
    logic [3:0] state;

    always #5 clk = ~clk;

    main_control_fsm #(.OPW(6)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .jr(jr), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
        .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
        .ALUop(ALUop), .instr_done(instr_done), .illegal_op(illegal_op), .state(state)
    );

    localparam logic [5:0] LW = 6'h23, SW = 6'h2B, RT = 6'h00;
    localparam logic [5:0] BEQ = 6'h04, JMP = 6'h02, ANDI = 6'h0C;

    logic [21:0] dut_vec;
    assign dut_vec = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                      ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUop,
                      instr_done, illegal_op, state};

    int n_pass  = 0;
    int n_total = 0;

    typedef struct { int st; bit mr; } step_t;
    step_t plan[$];

    logic [21:0] exp_vec;
    bit          exp_valid = 1'b0;
    bit          model_ill = 1'b0;

    function automatic bit legal(logic [5:0] op);
        return op inside {LW, SW, RT, BEQ, JMP, ANDI};
    endfunction

    // Control lines the specification lists for each step of an instruction
    function automatic logic [21:0] model_out(int st, bit mr, bit ill_dec, bit ill_flag);
        logic pcw = 0, pcwc = 0, iord = 0, mrd = 0, mw = 0, m2r = 0, irw = 0;
        logic sa = 0, rw = 0, rd = 0, done = 0;
        logic [1:0] pcs = 2'b00, sb = 2'b00, op = 2'b00;
        case (st)
            0:  begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
            1:  begin sb = 2'b11; done = ill_dec; end
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; done = 1; end
            5:  begin mw = 1; iord = 1; done = mr; end
            6:  begin sa = 1; op = 2'b10; end
            7:  begin op = 2'b10; rd = 1; rw = 1; done = 1; end
            8:  begin sa = 1; op = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
            9:  begin pcw = 1; pcs = 2'b10; done = 1; end
            10: begin sa = 1; sb = 2'b10; op = 2'b11; end
            11: begin op = 2'b11; rw = 1; done = 1; end
            12: begin pcw = 1; pcs = 2'b11; done = 1; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mw, m2r, irw, sa, rw, rd, pcs, sb, op,
                done, ill_flag, 4'(st)};
    endfunction

    // Expand one instruction into its cycle-by-cycle step list
    function automatic void build_plan(logic [5:0] op, bit jrv, int fs, int ms);
        plan.delete();
        for (int i = 0; i < fs; i++) plan.push_back('{0, 1'b0});
        plan.push_back('{0, 1'b1});
        plan.push_back('{1, 1'b1});
        case (op)
            LW: begin
                plan.push_back('{2, 1'b1});
                for (int i = 0; i < ms; i++) plan.push_back('{3, 1'b0});
                plan.push_back('{3, 1'b1});
                plan.push_back('{4, 1'b1});
            end
            SW: begin
                plan.push_back('{2, 1'b1});
                for (int i = 0; i < ms; i++) plan.push_back('{5, 1'b0});
                plan.push_back('{5, 1'b1});
            end
            RT: begin
                plan.push_back('{6, 1'b1});
                plan.push_back('{jrv ? 12 : 7, 1'b1});
            end
            BEQ:  plan.push_back('{8, 1'b1});
            JMP:  plan.push_back('{9, 1'b1});
            ANDI: begin
                plan.push_back('{10, 1'b1});
                plan.push_back('{11, 1'b1});
            end
            default: ;
        endcase
    endfunction

    task automatic check(input string name, input logic [21:0] act, input logic [21:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, expv, $time);
    endtask

    task automatic check_int(input string name, input int act, input int expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    always @(negedge clk) begin
        if (exp_valid) check("cycle", dut_vec, exp_vec);
    end

    // Drive one cycle of a step; called at posedge+1, returns at next posedge+1
    task automatic drive_step(input int st, input bit mr, input logic [5:0] op,
                              input bit jrv, output bit done_seen);
        bit ill_dec;
        opcode    = (st == 0) ? 6'($urandom) : op;
        jr        = (st == 6) ? jrv : 1'($urandom);
        mem_ready = (st == 0 || st == 3 || st == 5) ? mr : 1'($urandom);
        ill_dec   = (st == 1) && !legal(op);
        exp_vec   = model_out(st, mem_ready, ill_dec, model_ill);
        exp_valid = 1'b1;
        #3;
        done_seen = instr_done;
        @(posedge clk);
        #1;
        if (ill_dec) model_ill = 1'b1;
    endtask

    task automatic run_instr(input logic [5:0] op, input bit jrv, input int fs, input int ms);
        int dcnt = 0;
        bit d;
        build_plan(op, jrv, fs, ms);
        foreach (plan[i]) begin
            drive_step(plan[i].st, plan[i].mr, op, jrv, d);
            if (d) dcnt++;
        end
        check_int("done_pulses", dcnt, 1);
    endtask

    logic [5:0] rop;
    bit d0;

    initial begin
        reset = 1'b1; opcode = 6'h00; jr = 1'b0; mem_ready = 1'b1;
        #2;
        check("reset_state", dut_vec, model_out(0, 1'b0, 1'b0, 1'b0));

        // Pin the model against hand-computed values
        build_plan(LW, 0, 0, 0);   check_int("len_lw", plan.size(), 5);
        build_plan(SW, 0, 0, 0);   check_int("len_sw", plan.size(), 4);
        build_plan(RT, 0, 0, 0);   check_int("len_r", plan.size(), 4);
        build_plan(RT, 1, 0, 0);   check_int("len_jr", plan.size(), 4);
        build_plan(BEQ, 0, 0, 0);  check_int("len_beq", plan.size(), 3);
        build_plan(JMP, 0, 0, 0);  check_int("len_j", plan.size(), 3);
        build_plan(ANDI, 0, 0, 0); check_int("len_andi", plan.size(), 4);
        build_plan(LW, 0, 3, 0);   check_int("len_lw_fstall", plan.size(), 8);
        build_plan(SW, 0, 0, 1);   check_int("len_sw_mstall", plan.size(), 5);
        check("pin_beq", model_out(8, 1'b0, 1'b0, 1'b0), 22'b0100000100_01_00_01_1_0_1000);
        check("pin_fetch", model_out(0, 1'b1, 1'b0, 1'b0), 22'b1001001000_00_01_00_0_0_0000);

        @(posedge clk); #1;
        reset = 1'b0;

        // Directed instruction set walk
        run_instr(LW, 0, 0, 0);
        run_instr(RT, 0, 0, 0);
        run_instr(RT, 1, 0, 0);
        run_instr(LW, 0, 3, 0);
        run_instr(SW, 0, 0, 1);
        run_instr(BEQ, 0, 0, 0);
        run_instr(ANDI, 0, 0, 0);
        run_instr(6'h3F, 0, 0, 0);
        run_instr(JMP, 0, 0, 0);
        check_int("illegal_sticky", int'(illegal_op), 1);

        // Randomized instruction stream
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 7))
                0: rop = LW;
                1: rop = SW;
                2: rop = RT;
                3: rop = BEQ;
                4: rop = JMP;
                5: rop = ANDI;
                6: begin
                    rop = 6'($urandom);
                    while (legal(rop)) rop = 6'($urandom);
                end
                default: rop = RT;
            endcase
            run_instr(rop, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        // Asynchronous reset while lw sits in MEMRD
        drive_step(0, 1'b1, LW, 1'b0, d0);
        drive_step(1, 1'b1, LW, 1'b0, d0);
        drive_step(2, 1'b1, LW, 1'b0, d0);
        exp_valid = 1'b0;
        opcode = LW; mem_ready = 1'b1;
        #1;
        check_int("in_memrd", int'(state), 3);
        reset = 1'b1;
        #1;
        check("rst_async", dut_vec, model_out(0, 1'b0, 1'b0, 1'b0));
        model_ill = 1'b0;
        @(posedge clk); #1;
        check("rst_hold", dut_vec, model_out(0, 1'b0, 1'b0, 1'b0));
        reset = 1'b0;
        #1;
        check("rst_release", dut_vec, model_out(0, 1'b1, 1'b0, 1'b0));
        @(posedge clk); #1;
        drive_step(1, 1'b1, LW, 1'b0, d0);
        drive_step(2, 1'b1, LW, 1'b0, d0);
        drive_step(3, 1'b1, LW, 1'b0, d0);
        drive_step(4, 1'b1, LW, 1'b0, d0);
        run_instr(JMP, 0, 0, 0);
        exp_valid = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
